// File: rtl/pic_host_bus_master.sv
// pic_host_bus_master
//   CPU-side bus initiator for the 8259 PIC control logic. It turns single-byte
//   command requests into timed 8259 write/read cycles (WD/RD/A0/data_bus).
//   When auto_ack_en is set, it also answers INT with the two-pulse INTA
//   sequence and captures the vector byte driven on the second pulse.
//
// Ports
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (accepted only in IDLE)
//   cmd_rd, cmd_a0, cmd_data: cycle type, address line value, write byte
//   rsp_valid, rsp_data     : one-cycle pulse plus held byte from a read cycle
//   auto_ack_en             : enables automatic INTA handling
//   vector_valid, vector    : one-cycle pulse plus held vector byte
//   WD, RD, INTA            : active-low strobes, never more than one low
//   A0                      : address line
//   INT                     : interrupt request from the PIC
//   data_bus                : bidirectional PIC data bus
module pic_host_bus_master #(
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       auto_ack_en,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       WD,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  input  logic       INT,
  inout  wire  [7:0] data_bus
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP   = 4'd1,
    ST_STROBE  = 4'd2,
    ST_HOLD    = 4'd3,
    ST_RECOVER = 4'd4,
    ST_ACK1    = 4'd5,
    ST_ACK_GAP = 4'd6,
    ST_ACK2    = 4'd7,
    ST_ACK_END = 4'd8
  } state_t;

  localparam logic [3:0] PULSE_LOAD    = 4'(PULSE_CYCLES);
  localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_CYCLES);

  // Dwell time loaded into the counter when a state is entered.
  function automatic logic [3:0] dwell_load(input state_t st);
    case (st)
      ST_STROBE, ST_ACK1, ST_ACK2: dwell_load = PULSE_LOAD;
      ST_RECOVER, ST_ACK_GAP:      dwell_load = RECOVERY_LOAD;
      ST_IDLE:                     dwell_load = 4'd0;
      default:                     dwell_load = 4'd1;
    endcase
  endfunction

  state_t     state_r, state_next_s;
  logic [3:0] cnt_r, cnt_next_s;
  logic       cmd_rd_r, cmd_rd_next_s;
  logic       a0_next_s;
  logic [7:0] wdata_r, wdata_next_s;
  logic       drive_en_r, drive_en_next_s;
  logic       wd_next_s, rd_next_s, inta_next_s;
  logic       int_req_s, last_s;

  assign int_req_s = INT & auto_ack_en;
  assign last_s    = (cnt_r <= 4'd1);

  // Ready must see INT in the same cycle so an interrupt wins over a
  // simultaneous command; everything else it uses is registered.
  assign cmd_ready = (state_r == ST_IDLE) & ~int_req_s & ~reset;

  assign data_bus = drive_en_r ? wdata_r : 8'bz;

  // Next-state, counter and next-output decode.
  always_comb begin
    state_next_s  = state_r;
    cmd_rd_next_s = cmd_rd_r;
    a0_next_s     = A0;
    wdata_next_s  = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (int_req_s) begin
          state_next_s = ST_ACK1;
        end else if (cmd_valid) begin
          state_next_s  = ST_SETUP;
          cmd_rd_next_s = cmd_rd;
          a0_next_s     = cmd_a0;
          wdata_next_s  = cmd_data;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP:   state_next_s = ST_STROBE;
      ST_STROBE:  state_next_s = last_s ? ST_HOLD : ST_STROBE;
      ST_HOLD:    state_next_s = ST_RECOVER;
      ST_RECOVER: state_next_s = last_s ? ST_IDLE : ST_RECOVER;
      ST_ACK1:    state_next_s = last_s ? ST_ACK_GAP : ST_ACK1;
      ST_ACK_GAP: state_next_s = last_s ? ST_ACK2 : ST_ACK_GAP;
      ST_ACK2:    state_next_s = last_s ? ST_ACK_END : ST_ACK2;
      ST_ACK_END: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase

    if (state_next_s != state_r) begin
      cnt_next_s = dwell_load(state_next_s);
    end else if (cnt_r > 4'd1) begin
      cnt_next_s = cnt_r - 4'd1;
    end else begin
      cnt_next_s = cnt_r;
    end

    // Strobes/drive are decoded from the next state so the registered
    // outputs line up with the state they belong to.
    wd_next_s       = ~((state_next_s == ST_STROBE) & ~cmd_rd_next_s);
    rd_next_s       = ~((state_next_s == ST_STROBE) & cmd_rd_next_s);
    inta_next_s     = ~((state_next_s == ST_ACK1) | (state_next_s == ST_ACK2));
    drive_en_next_s = ~cmd_rd_next_s & ((state_next_s == ST_SETUP) |
                                        (state_next_s == ST_STROBE) |
                                        (state_next_s == ST_HOLD));
  end

  // State, counter, latched command and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      cmd_rd_r     <= 1'b0;
      wdata_r      <= 8'h00;
      drive_en_r   <= 1'b0;
      WD           <= 1'b1;
      RD           <= 1'b1;
      INTA         <= 1'b1;
      A0           <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      vector_valid <= 1'b0;
      vector       <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      cmd_rd_r     <= cmd_rd_next_s;
      wdata_r      <= wdata_next_s;
      drive_en_r   <= drive_en_next_s;
      WD           <= wd_next_s;
      RD           <= rd_next_s;
      INTA         <= inta_next_s;
      A0           <= a0_next_s;
      // Pulses fire on the edge that returns the FSM to IDLE.
      rsp_valid    <= (state_r == ST_RECOVER) & last_s & cmd_rd_r;
      vector_valid <= (state_r == ST_ACK_END);
      // Bus is sampled on the last low cycle, while the PIC still drives it.
      if ((state_r == ST_STROBE) & last_s & cmd_rd_r) begin
        rsp_data <= data_bus;
      end else begin
        rsp_data <= rsp_data;
      end
      if ((state_r == ST_ACK2) & last_s) begin
        vector <= data_bus;
      end else begin
        vector <= vector;
      end
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Self-checking bench for pic_host_bus_master. Instance dut_a uses the default
// timing (2-cycle strobes, 1-cycle recovery) and is checked by a scoreboard
// monitor; instance dut_b uses 1-cycle strobes and 3-cycle recovery.
module tb_pic_host_bus_master;

  localparam int PULSE_A = 2;
  localparam int REC_A   = 1;

  logic clk;
  logic reset;

  // dut_a signals
  logic       cmd_valid, cmd_ready, cmd_rd, cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid, vector_valid, auto_ack_en;
  logic [7:0] rsp_data, vector;
  logic       WD, RD, A0, INTA, INT;
  wire  [7:0] data_bus;
  logic [7:0] pic_rd_val, pic_vec_val;

  // dut_b signals
  logic       b_cmd_valid, b_cmd_ready, b_cmd_rd, b_cmd_a0;
  logic [7:0] b_cmd_data;
  logic       b_rsp_valid, b_vector_valid, b_auto_ack_en;
  logic [7:0] b_rsp_data, b_vector;
  logic       b_WD, b_RD, b_A0, b_INTA, b_INT;
  wire  [7:0] b_data_bus;
  logic [7:0] b_vec_val;

  // PIC-side bus models: drive only while the relevant strobe is low
  assign data_bus   = (!RD) ? pic_rd_val : ((!INTA) ? pic_vec_val : 8'bz);
  assign b_data_bus = (!b_RD) ? 8'h00 : ((!b_INTA) ? b_vec_val : 8'bz);

  pic_host_bus_master dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .auto_ack_en(auto_ack_en), .vector_valid(vector_valid), .vector(vector),
    .WD(WD), .RD(RD), .A0(A0), .INTA(INTA), .INT(INT), .data_bus(data_bus)
  );

  pic_host_bus_master #(.PULSE_CYCLES(1), .RECOVERY_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rd(b_cmd_rd),
    .cmd_a0(b_cmd_a0), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .auto_ack_en(b_auto_ack_en), .vector_valid(b_vector_valid), .vector(b_vector),
    .WD(b_WD), .RD(b_RD), .A0(b_A0), .INTA(b_INTA), .INT(b_INT), .data_bus(b_data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_wr_q[$];   // {a0, data}
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_vec_q[$];

  logic [7:0] bus_z = 8'bz;
  bit  drop_wr = 1'b0;
  time t_vec = 0;
  time t_wd_fall = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Issue one command on dut_a; for reads d is the byte the PIC model returns.
  task automatic issue(input logic rd, input logic a0, input logic [7:0] d, input bit expect_it);
    int k;
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_a0    = a0;
    cmd_data  = rd ? 8'($urandom) : d;
    k = 0;
    #1;
    while (!cmd_ready && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      if (rd) begin
        pic_rd_val = d;
        if (expect_it) exp_rd_q.push_back(d);
      end else if (expect_it) begin
        exp_wr_q.push_back({a0, d});
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // PIC model raising INT; it drops INT once the first INTA pulse is seen.
  task automatic raise_int(input logic [7:0] v);
    int k;
    pic_vec_val = v;
    exp_vec_q.push_back(v);
    INT = 1'b1;
    k = 0;
    while (INTA !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("inta_started", INTA, 0);
    INT = 1'b0;
    k = 0;
    while (vector_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("vector_done", vector_valid, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!cmd_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", cmd_ready, 1);
  endtask

  // dut_b: timing with 1-cycle strobes and 3-cycle recovery
  task automatic test_b();
    int busy, wd_lows, lo, hi, gap, pidx;
    int pw[2];
    logic [7:0] seen;
    logic [7:0] vcap;
    bit got_vec;
    b_cmd_rd = 1'b0; b_cmd_a0 = 1'b1; b_cmd_data = 8'h3C; b_cmd_valid = 1'b1;
    #1;
    check("b_ready", b_cmd_ready, 1);
    @(negedge clk);
    b_cmd_valid = 1'b0;
    busy = 0; wd_lows = 0; seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (b_cmd_ready) break;
      busy++;
      if (!b_WD) begin
        wd_lows++;
        seen = b_data_bus;
      end
      @(negedge clk);
    end
    check("b_write_busy_cycles", busy, 6);
    check("b_wd_low_cycles", wd_lows, 1);
    check("b_wr_data", seen, 8'h3C);

    b_vec_val = 8'hC3; b_auto_ack_en = 1'b1; b_INT = 1'b1;
    lo = 0; hi = 0; gap = -1; pidx = 0; pw[0] = 0; pw[1] = 0; got_vec = 1'b0; vcap = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!b_INTA) begin
        b_INT = 1'b0;
        if (lo == 0 && pidx == 1) gap = hi;
        lo++;
        hi = 0;
      end else begin
        if (lo != 0) begin
          if (pidx < 2) pw[pidx] = lo;
          pidx++;
          lo = 0;
        end
        hi++;
      end
      if (b_vector_valid) begin
        got_vec = 1'b1;
        vcap = b_vector;
      end
    end
    check("b_inta_pulses", pidx, 2);
    check("b_inta_width1", pw[0], 1);
    check("b_inta_width2", pw[1], 1);
    check("b_inta_gap", gap, 3);
    check("b_vector_valid", got_vec, 1);
    check("b_vector", vcap, 8'hC3);
  endtask

  // Scoreboard monitor for dut_a, sampling on the falling edge
  initial begin : monitor
    int lows, wd_cnt, rd_cnt, inta_lo, inta_hi, inta_idx;
    logic [7:0] prev_bus, wd_data;
    logic wd_a0, prev_rsp, prev_vec;
    logic [8:0] e;
    logic [7:0] ev;
    wd_cnt = 0; rd_cnt = 0; inta_lo = 0; inta_hi = 0; inta_idx = 0;
    prev_bus = 8'bz; wd_data = 8'h00; wd_a0 = 1'b0; prev_rsp = 1'b0; prev_vec = 1'b0;
    forever begin
      @(negedge clk);
      lows = int'(!WD) + int'(!RD) + int'(!INTA);
      check("strobe_exclusive", lows <= 1, 1);
      if (lows != 0) check("busy_not_ready", cmd_ready, 0);

      if (!WD) begin
        if (wd_cnt == 0) begin
          check("wr_setup_data", data_bus, prev_bus);
          wd_data = data_bus;
          wd_a0 = A0;
          t_wd_fall = $time;
        end else begin
          check("wr_data_stable", data_bus, wd_data);
        end
        wd_cnt++;
      end else if (wd_cnt != 0) begin
        if (!drop_wr) begin
          check("wd_width", wd_cnt, PULSE_A);
          check("wr_hold_data", data_bus, wd_data);
          check("wr_expected_pending", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check("wr_a0", wd_a0, e[8]);
            check("wr_data", wd_data, e[7:0]);
          end
        end
        wd_cnt = 0;
      end

      if (!RD) begin
        if (rd_cnt == 0) check("rd_setup_released", prev_bus, bus_z);
        rd_cnt++;
      end else if (rd_cnt != 0) begin
        check("rd_width", rd_cnt, PULSE_A);
        check("rd_hold_released", data_bus, bus_z);
        rd_cnt = 0;
      end

      if (!INTA) begin
        if (inta_lo == 0 && inta_idx == 1) check("inta_gap", inta_hi, REC_A);
        inta_lo++;
        inta_hi = 0;
      end else begin
        if (inta_lo != 0) begin
          check("inta_width", inta_lo, PULSE_A);
          inta_idx = 1 - inta_idx;
          inta_lo = 0;
        end
        inta_hi++;
      end

      if (rsp_valid) begin
        check("rsp_single_pulse", prev_rsp, 0);
        check("rsp_expected_pending", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) begin
          ev = exp_rd_q.pop_front();
          check("rsp_data", rsp_data, ev);
        end
      end
      if (vector_valid) begin
        t_vec = $time;
        check("vec_single_pulse", prev_vec, 0);
        check("vec_expected_pending", exp_vec_q.size() != 0, 1);
        if (exp_vec_q.size() != 0) begin
          ev = exp_vec_q.pop_front();
          check("vector", vector, ev);
        end
      end
      prev_rsp = rsp_valid;
      prev_vec = vector_valid;
      prev_bus = data_bus;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int quiet;
    int unsigned r;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    auto_ack_en = 1'b0; INT = 1'b0; pic_rd_val = 8'h00; pic_vec_val = 8'h00;
    b_cmd_valid = 1'b0; b_cmd_rd = 1'b0; b_cmd_a0 = 1'b0; b_cmd_data = 8'h00;
    b_auto_ack_en = 1'b0; b_INT = 1'b0; b_vec_val = 8'h00;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wd", WD, 1);
    check("rst_rd", RD, 1);
    check("rst_inta", INTA, 1);
    check("rst_a0", A0, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_vector_valid", vector_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_vector", vector, 8'h00);
    check("rst_data_bus", data_bus, bus_z);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    test_b();

    // program sequence
    issue(1'b0, 1'b0, 8'h15, 1'b1);
    issue(1'b0, 1'b1, 8'hF8, 1'b1);
    issue(1'b0, 1'b1, 8'hFF, 1'b1);
    issue(1'b0, 1'b1, 8'h1F, 1'b1);
    issue(1'b0, 1'b1, 8'hAA, 1'b1);
    wait_idle();

    // read of 0x60 with A0=0
    issue(1'b1, 1'b0, 8'h60, 1'b1);
    wait_idle();
    @(negedge clk);
    check("rsp_data_held", rsp_data, 8'h60);

    // INT ignored while auto-ack disabled
    INT = 1'b1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (!INTA) quiet++;
    end
    check("int_ignored_no_inta", quiet, 0);
    issue(1'b0, 1'b1, 8'h5A, 1'b1);
    wait_idle();
    INT = 1'b0;
    auto_ack_en = 1'b1;
    @(negedge clk);

    // auto-acknowledge with vector 0xFF
    raise_int(8'hFF);
    wait_idle();
    check("vector_held", vector, 8'hFF);

    // INT and a write arriving together: acknowledge first
    fork
      issue(1'b0, 1'b0, 8'hAA, 1'b1);
      raise_int(8'h21);
    join
    repeat (10) @(negedge clk);
    check("int_before_write", t_wd_fall > t_vec, 1);
    wait_idle();

    // reset during the 2nd STROBE cycle of a write
    drop_wr = 1'b1;
    issue(1'b0, 1'b1, 8'h77, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wd", WD, 1);
    check("midrst_bus", data_bus, bus_z);
    check("midrst_a0", A0, 0);
    reset = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (!WD || !RD || !INTA || rsp_valid || vector_valid) quiet++;
    end
    check("midrst_quiet", quiet, 0);
    check("midrst_ready", cmd_ready, 1);
    drop_wr = 1'b0;

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) issue(1'b0, 1'($urandom), 8'($urandom), 1'b1);
      else if (r < 8) issue(1'b1, 1'($urandom), 8'($urandom), 1'b1);
      else raise_int(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("vec_queue_drained", exp_vec_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- CPU-side bus initiator for the 8259 PIC control logic; the opposite end of the WD/RD/A0/INTA/data_bus interface.
- Turns single-byte command requests into properly timed 8259 write and read cycles. Used to program ICW1–ICW4 and OCWs, and to read IRR/ISR.
- Watches INT. When auto-acknowledge is enabled, it runs the two-pulse INTA sequence itself and captures the interrupt vector byte.
- Sits between the system/testbench sequencer and the PIC top level.

Parameters:
- PULSE_CYCLES, 2: strobe (WD/RD/INTA) low width in clk cycles; legal range 1..15.
- RECOVERY_CYCLES, 1: strobe-high gap after HOLD, and between the two INTA pulses; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when a command can be accepted this cycle.
- cmd_rd  input  1  0 = write cycle, 1 = read cycle.
- cmd_a0  input  1  A0 value for the cycle.
- cmd_data  input  8  write byte.
- rsp_valid  output  1  one-cycle pulse; rsp_data holds the byte read.
- rsp_data  output  8  captured read byte; holds until next read.
- auto_ack_en  input  1  enables automatic INTA handling.
- vector_valid  output  1  one-cycle pulse; vector holds the captured vector.
- vector  output  8  byte captured on the 2nd INTA; holds until next capture.
- WD  output  1  active-low write strobe.
- RD  output  1  active-low read strobe.
- A0  output  1  address line.
- INTA  output  1  active-low interrupt acknowledge.
- INT  input  1  interrupt request from PIC, active-high.
- data_bus  inout  8  PIC data bus; driven only during write SETUP/STROBE/HOLD, otherwise 8'bz.

Behaviour:
- Reset values:
  - WD=RD=INTA=1, A0=0, data_bus=z.
  - cmd_ready=0 during reset, 1 in IDLE afterward.
  - rsp_valid=vector_valid=0, rsp_data=vector=8'h00.
  - State=IDLE, counter=0.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER, ACK1, ACK_GAP, ACK2, ACK_END.
- IDLE:
  - cmd_ready=1 only in IDLE, and only when not (INT & auto_ack_en).
  - If INT & auto_ack_en: go to ACK1. The interrupt has priority; a simultaneous cmd_valid is not accepted (cmd_ready=0 that cycle).
  - Else if cmd_valid: latch cmd_rd/cmd_a0/cmd_data and go to SETUP.
- SETUP (1 cycle):
  - A0 = latched value.
  - Write: data_bus driven with latched byte.
  - Strobes high.
- STROBE (PULSE_CYCLES cycles): WD low for writes, or RD low for reads; A0 and data held.
- Read capture: data_bus is sampled into rsp_data on the last STROBE cycle.
- HOLD (1 cycle): strobe high; write data still driven; A0 held.
- RECOVER (RECOVERY_CYCLES cycles): data_bus released; return to IDLE.
  - Read: rsp_valid pulses on the first IDLE cycle.
- Write latency, defaults: accept at edge N; SETUP N+1; WD low N+2..N+3; HOLD N+4; RECOVER N+5; IDLE with cmd_ready=1 at N+6.
- INTA sequence:
  - ACK1: INTA low for PULSE_CYCLES.
  - ACK_GAP: INTA high for RECOVERY_CYCLES.
  - ACK2: INTA low for PULSE_CYCLES; data_bus sampled into vector on its last cycle.
  - ACK_END: 1 cycle INTA high, then IDLE; vector_valid pulses on entry to IDLE.
  - Throughout: WD=RD=1 and data_bus=z.
- INT deasserting during ACK1/ACK_GAP/ACK2 does not abort; both pulses always complete.
- INT still high on return to IDLE starts a new sequence immediately.
- auto_ack_en=0: INT is ignored.
- Never more than one strobe low in any cycle; WD, RD and INTA are mutually exclusive.
- Counter is 4 bits; it reloads on every state entry and counts down to 1.
- Reset mid-operation: at the next edge all strobes go high and data_bus goes z. The in-flight command is dropped with no rsp_valid or vector_valid. Outputs take their reset values.
- cmd_valid held high across back-to-back commands: each one is accepted only in IDLE; there is no pipelining.

Test Plan:
1. Program sequence (defaults) -> each write has WD low exactly 2 cycles, the data_bus value stable from SETUP through HOLD, and cmd_ready low during every cycle. Commands:
   - ICW1 0x15 with A0=0
   - ICW2 0xF8 with A0=1
   - ICW3 0xFF with A0=1
   - ICW4 0x1F with A0=1
   - OCW1 0xAA with A0=1
2. Read with cmd_a0=0; bench model drives 0x60 while RD=0 -> RD low 2 cycles, rsp_data=0x60, rsp_valid high exactly 1 cycle, data_bus never driven by the DUT.
3. auto_ack_en=1, INT raised; model drives 0xFF during the 2nd INTA -> two INTA low pulses of 2 cycles with a 1-cycle gap, vector=0xFF, single vector_valid pulse.
4. INT and cmd_valid rise in the same cycle -> INTA sequence runs first; the write (0xAA) starts only after vector_valid.
5. reset asserted during the 2nd STROBE cycle of a write -> WD=1 and data_bus=z at the next edge; no further activity until a new command.
6. PULSE_CYCLES=1, RECOVERY_CYCLES=3 build -> 1-cycle strobes, 3-cycle recovery; a write takes 6 cycles from accept to IDLE.
